rns_conv_scheduler: RTL and testbench
=====================================

# rns_conv_scheduler

Sequencer that converts one signed binary operand into its full residue vector by time-sharing a single modular-accumulate datapath across all moduli of the RNS base. It sits between the binary front end and the RNS arithmetic lanes. It accepts an operand on a valid/ready handshake, walks each modulus bit-serially using the per-modulus 2^j mod m coefficient table, applies the sign correction, and presents all residues together on an output handshake.

## Interface
- WIDTH, 32, operand width, two's complement.
- NUM_MOD, 4, number of moduli in the base.
- MOD_SIZE, 4, bits per residue and per modulus.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- moduli  in  NUM_MOD*MOD_SIZE  modulus k at [k*MOD_SIZE +: MOD_SIZE]; must be stable while busy.
- coeff_table  in  NUM_MOD*WIDTH*MOD_SIZE  entry (k,j) = 2^j mod m_k at [(k*WIDTH+j)*MOD_SIZE +: MOD_SIZE]; must be stable while busy.
- in_valid  in  1  operand offered.
- in_ready  out  1  high only in IDLE.
- in_data  in  WIDTH  signed operand.
- out_valid  out  1  residue vector valid.
- out_ready  in  1  consumer accepts.
- out_res  out  NUM_MOD*MOD_SIZE  residue k at [k*MOD_SIZE +: MOD_SIZE].
- out_err  out  NUM_MOD  bit k set when m_k < 2.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ACCUM, STORE, DONE.
- IDLE: in_ready=1. On in_valid, the block captures the magnitude |in_data| as an unsigned WIDTH value and the sign. It then clears k, j and acc, and moves to ACCUM, or to STORE when modulus 0 takes the bypass.
- ACCUM: one bit per cycle. acc' = acc + (mag[j] ? coeff(k,j) : 0), then acc' is reduced by m_k once when acc' >= m_k. The accumulator is MOD_SIZE+1 bits wide. Coefficients are < m and acc is < m, so a single subtraction is sufficient. After j = WIDTH-1 the FSM moves to STORE.
- STORE: computes r = acc for the serial path, or mag[MOD_SIZE-1:0] & (m_k-1) for the bypass path.
  - If the operand was negative and r != 0, r becomes m_k - r.
  - If m_k < 2, r = 0 and out_err[k] is set.
  - The result is written into slot k. Then k increments and j and acc are cleared.
  - The next state is ACCUM or STORE for modulus k+1; after k = NUM_MOD-1 it is DONE.
- DONE: out_valid=1 and out_res/out_err are held. On out_ready the FSM returns to IDLE. The block does not accept an input in that same cycle.
- The most negative operand (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1) and is processed normally.
- Power-of-two moduli are detected as (m & (m-1)) == 0 with m >= 2.

## Timing
- Reset: state IDLE. in_ready=1 after the first edge following deassertion and is combinationally 1 in IDLE. out_valid=0, out_res=0, out_err=0, busy=0.
- Reset mid-operation aborts the conversion and discards all partial results.
- Per modulus: a serial modulus takes WIDTH+1 cycles; a bypassed modulus takes 1 cycle.
- Latency from the accept edge to out_valid: the sum of the per-modulus cycles, plus 1.
- Throughput: at most one operand per latency+2 cycles.
- out_res changes only in STORE. It is stable throughout DONE.

## Configuration
- RNS_POW2_BYPASS_EN defined: power-of-two moduli skip ACCUM, with a 1-cycle STORE that uses the mask path.
- RNS_POW2_BYPASS_EN undefined: every modulus uses the serial path. Residues are identical to the defined case; only the latency differs.

## Structure
- Package rns_pkg holds:
  - the state enum;
  - default WIDTH, NUM_MOD and MOD_SIZE;
  - the is_pow2 function;
  - the slice-index helpers for the coeff_table and out_res packing.
- Sub-module rns_mod_accum: one combinational step of conditional add plus conditional subtract (inputs acc, coeff, bit, m; output acc'). It is instantiated once and shared across moduli.

## Test plan
- moduli {7,8,9,5}, in_data=100 -> out_res {2,4,1,0}, out_err=0. Latency 133 without the macro, 101 with it.
- in_data=-100 -> {5,4,8,0}. The zero residue for modulus 5 stays 0, with no m-r correction.
- in_data=-2^31 -> {5,0,7,2}.
- in_data=0 and in_data=-1 -> {0,0,0,0} and {6,7,8,4}.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_res are stable and in_ready=0. out_ready=1 -> IDLE on the next cycle.
- moduli {1,8,0,5}, in_data=13 -> out_res {0,5,0,3}, out_err=4'b0101. Assert reset mid-ACCUM -> all outputs 0, and a subsequent operand converts correctly.

Source files
------------

// File: rtl/rns_pkg.sv
// rns_pkg: shared types, defaults and helpers for the RNS conversion scheduler.
//   state_e      - scheduler FSM states
//   DEF_*        - default operand width, modulus count and residue width
//   is_pow2      - power-of-two modulus test (m >= 2)
//   coeff_idx    - LSB of entry (k,j) in the flattened coefficient table
//   res_idx      - LSB of slot k in the flattened modulus / residue vectors
package rns_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_MOD  = 4;
    localparam int DEF_MOD_SIZE = 4;

    function automatic logic is_pow2(input logic [31:0] m);
        return (m >= 32'd2) && ((m & (m - 32'd1)) == 32'd0);
    endfunction

    function automatic int coeff_idx(input int k, input int j, input int width, input int msize);
        return (k * width + j) * msize;
    endfunction

    function automatic int res_idx(input int k, input int msize);
        return k * msize;
    endfunction

endpackage

// File: rtl/rns_mod_accum.sv
// rns_mod_accum: one combinational modular-accumulate step.
//   acc_i   - running accumulator (< m_i), MOD_SIZE+1 bits
//   coeff_i - 2^j mod m_i
//   bit_i   - operand magnitude bit j
//   m_i     - current modulus
//   acc_o   - (acc_i + (bit_i ? coeff_i : 0)) mod m_i
// Both addends are below m_i, so one conditional subtraction fully reduces.
module rns_mod_accum
    import rns_pkg::*;
#(
    parameter int MOD_SIZE = DEF_MOD_SIZE
) (
    input  logic [MOD_SIZE:0]   acc_i,
    input  logic [MOD_SIZE-1:0] coeff_i,
    input  logic                bit_i,
    input  logic [MOD_SIZE-1:0] m_i,
    output logic [MOD_SIZE:0]   acc_o
);

    logic [MOD_SIZE:0] sum;
    logic [MOD_SIZE:0] m_ext;

    always_comb begin
        m_ext = {1'b0, m_i};
        sum   = acc_i + (bit_i ? {1'b0, coeff_i} : '0);
        acc_o = (sum >= m_ext) ? (sum - m_ext) : sum;
    end

endmodule

// File: rtl/rns_conv_scheduler.sv
// rns_conv_scheduler: converts one signed binary operand into its residue
// vector by time-sharing a single modular-accumulate step over all moduli.
//   clk, reset     - clock, asynchronous active-high reset
//   moduli         - modulus k at [k*MOD_SIZE +: MOD_SIZE] (stable while busy)
//   coeff_table    - entry (k,j) = 2^j mod m_k (stable while busy)
//   in_valid/in_ready/in_data    - operand handshake (ready only in IDLE)
//   out_valid/out_ready/out_res  - residue vector handshake
//   out_err        - bit k set when m_k < 2
//   busy           - high in every state except IDLE
// Optional feature macro RNS_POW2_BYPASS_EN: power-of-two moduli skip the
// serial walk and take a single mask-based STORE cycle.
module rns_conv_scheduler
    import rns_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_MOD  = DEF_NUM_MOD,
    parameter int MOD_SIZE = DEF_MOD_SIZE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MOD*MOD_SIZE-1:0]       moduli,
    input  logic [NUM_MOD*WIDTH*MOD_SIZE-1:0] coeff_table,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_MOD*MOD_SIZE-1:0]       out_res,
    output logic [NUM_MOD-1:0]                out_err,
    output logic                              busy
);

    localparam int KW = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;
    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_MOD - 1);
    localparam logic [JW-1:0] J_LAST = JW'(WIDTH - 1);

    state_e                            state_q;
    logic [KW-1:0]                     k_q;
    logic [JW-1:0]                     j_q;
    logic [MOD_SIZE:0]                 acc_q;
    logic [WIDTH-1:0]                  mag_q;
    logic                              neg_q;
    logic                              init_q;
    logic                              out_valid_q;
    logic                              busy_q;
    logic [NUM_MOD-1:0][MOD_SIZE-1:0]  res_q;
    logic [NUM_MOD-1:0]                err_q;

    logic [WIDTH-1:0]    mag_d;
    logic [MOD_SIZE-1:0] m_cur;
    logic [MOD_SIZE-1:0] coeff_cur;
    logic [MOD_SIZE:0]   acc_d;
    logic                byp_cur;
    logic                byp_nxt;
    logic                byp_first;
    logic [MOD_SIZE-1:0] r_base;
    logic [MOD_SIZE-1:0] r_store;
    logic                err_store;

    // Two's complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    assign mag_d = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

    always_comb begin
        m_cur = '0;
        for (int i = 0; i < NUM_MOD; i++) begin
            if (KW'(i) == k_q) m_cur = moduli[res_idx(i, MOD_SIZE) +: MOD_SIZE];
        end
        coeff_cur = coeff_table[coeff_idx(int'(k_q), int'(j_q), WIDTH, MOD_SIZE) +: MOD_SIZE];
    end

`ifdef RNS_POW2_BYPASS_EN
    logic [MOD_SIZE-1:0] m_nxt;

    always_comb begin
        m_nxt = '0;
        for (int i = 0; i < NUM_MOD; i++) begin
            if (i == int'(k_q) + 1) m_nxt = moduli[res_idx(i, MOD_SIZE) +: MOD_SIZE];
        end
    end

    assign byp_cur   = is_pow2(32'(m_cur));
    assign byp_nxt   = is_pow2(32'(m_nxt));
    assign byp_first = is_pow2(32'(moduli[MOD_SIZE-1:0]));
`else
    assign byp_cur   = 1'b0;
    assign byp_nxt   = 1'b0;
    assign byp_first = 1'b0;
`endif

    rns_mod_accum #(.MOD_SIZE(MOD_SIZE)) u_accum (
        .acc_i   (acc_q),
        .coeff_i (coeff_cur),
        .bit_i   (mag_q[j_q]),
        .m_i     (m_cur),
        .acc_o   (acc_d)
    );

    // Residue for slot k: serial accumulator or low-bit mask, then sign fix.
    always_comb begin
        r_base    = byp_cur ? (mag_q[MOD_SIZE-1:0] & (m_cur - MOD_SIZE'(1)))
                            : acc_q[MOD_SIZE-1:0];
        r_store   = r_base;
        err_store = (m_cur < MOD_SIZE'(2));
        if (neg_q && (r_base != '0)) r_store = m_cur - r_base;
        if (err_store)               r_store = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            err_q       <= '0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mag_q   <= mag_d;
                        neg_q   <= in_data[WIDTH-1];
                        k_q     <= '0;
                        j_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= byp_first ? S_STORE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    if (j_q == J_LAST) state_q <= S_STORE;
                    else               j_q     <= j_q + JW'(1);
                end
                S_STORE: begin
                    res_q[k_q] <= r_store;
                    err_q[k_q] <= err_store;
                    j_q        <= '0;
                    acc_q      <= '0;
                    if (k_q == K_LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        state_q <= byp_nxt ? S_STORE : S_ACCUM;
                    end
                end
                S_DONE: begin
                    // Handshake cycle only returns to IDLE; no same-cycle accept.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready waits one edge after reset release, then tracks IDLE directly.
    assign in_ready  = (state_q == S_IDLE) && init_q;
    assign out_valid = out_valid_q;
    assign out_res   = res_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rns_conv_scheduler.sv
// tb_rns_conv_scheduler: table-driven and scoreboard check of rns_conv_scheduler.
// Build with or without RNS_POW2_BYPASS_EN; expected latency follows the macro.
module tb_rns_conv_scheduler;

    localparam int W  = 32;
    localparam int NM = 4;
    localparam int MS = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NM*MS-1:0]   moduli;
    logic [NM*W*MS-1:0] coeff_table;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NM*MS-1:0]   out_res;
    logic [NM-1:0]      out_err;
    logic               busy;

    rns_conv_scheduler #(.WIDTH(W), .NUM_MOD(NM), .MOD_SIZE(MS)) dut (
        .clk         (clk),
        .reset       (reset),
        .moduli      (moduli),
        .coeff_table (coeff_table),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_err     (out_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] din;
        logic [15:0] mods;
        logic [15:0] res;
        logic [3:0]  err;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic build_coeff(input logic [15:0] mods);
        int m, p;
        for (int k = 0; k < NM; k++) begin
            m = int'(mods[k*MS +: MS]);
            p = (m < 2) ? 0 : 1;
            for (int j = 0; j < W; j++) begin
                coeff_table[(k*W + j)*MS +: MS] = 4'(p);
                if (m >= 2) p = (p * 2) % m;
            end
        end
    endtask

    // Reference residue/err/latency computed from arithmetic, not the datapath.
    function automatic exp_t model(input logic [31:0] din, input logic [15:0] mods);
        exp_t        e;
        logic [31:0] mag;
        logic        neg;
        int          m;
        longint      r;
        neg   = din[31];
        mag   = neg ? (~din + 32'd1) : din;
        e.res = '0;
        e.err = '0;
        e.lat = 1;
        for (int k = 0; k < NM; k++) begin
            m = int'(mods[k*MS +: MS]);
            if (m < 2) begin
                e.err[k] = 1'b1;
                r = 0;
            end else begin
                r = longint'({32'b0, mag}) % longint'(m);
                if (neg && r != 0) r = longint'(m) - r;
            end
            e.res[k*MS +: MS] = 4'(r);
`ifdef RNS_POW2_BYPASS_EN
            if (m >= 2 && (m & (m - 1)) == 0) e.lat += 1;
            else                              e.lat += W + 1;
`else
            e.lat += W + 1;
`endif
        end
        return e;
    endfunction

    task automatic run_op(input logic [31:0] din, input logic [15:0] mods,
                          input exp_t e, input int stall);
        exp_t got;
        int   cnt;
        moduli = mods;
        build_coeff(mods);
        sb.push_back(e);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!out_valid && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        got = sb.pop_front();
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 required=1 after %0d cycles", cnt);
            return;
        end
        chk("out_res", 32'(out_res), 32'(got.res));
        chk("out_err", 32'(out_err), 32'(got.err));
        chk("latency", 32'(cnt), 32'(got.lat));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_res", 32'(out_res), 32'(got.res));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        // During a stalled run also offer a new operand on the handshake cycle.
        if (stall > 0) begin
            in_valid = 1'b1;
            in_data  = din;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[6];
    exp_t e;

    initial begin
        vecs[0] = '{32'd100,        16'h5987, 16'h0142, 4'b0000};
        vecs[1] = '{-32'sd100,      16'h5987, 16'h0845, 4'b0000};
        vecs[2] = '{32'h8000_0000,  16'h5987, 16'h2705, 4'b0000};
        vecs[3] = '{32'd0,          16'h5987, 16'h0000, 4'b0000};
        vecs[4] = '{32'hFFFF_FFFF,  16'h5987, 16'h4876, 4'b0000};
        vecs[5] = '{32'd13,         16'h5081, 16'h3050, 4'b0101};

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        moduli      = 16'h5987;
        coeff_table = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_res", 32'(out_res), 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Table: residues are fixed constants, latency from the model.
        for (int i = 0; i < 6; i++) begin
            e     = model(vecs[i].din, vecs[i].mods);
            e.res = vecs[i].res;
            e.err = vecs[i].err;
            run_op(vecs[i].din, vecs[i].mods, e, 0);
        end

        // Backpressure: hold DONE for 10 cycles.
        run_op(32'd100, 16'h5987, model(32'd100, 16'h5987), 10);

        // Random operands on two bases.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            logic [15:0] mb;
            d  = $urandom;
            mb = (i < 2) ? 16'h5987 : 16'h2DB3;
            run_op(d, mb, model(d, mb), 0);
        end

        // Reset in the middle of ACCUM after an operand that left out_err set.
        run_op(32'd13, 16'h5081, model(32'd13, 16'h5081), 0);
        in_valid = 1'b1;
        in_data  = 32'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_res", 32'(out_res), 32'd0);
        chk("abort_out_err", 32'(out_err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        e     = model(32'd100, 16'h5987);
        e.res = 16'h0142;
        run_op(32'd100, 16'h5987, e, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
